fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the toy CPU. It sits directly upstream of the instruction decoder.
- Owns the program counter and fetches 16-bit instruction words over a req/ack instruction-memory port.
- Holds each fetched word in an instruction register and presents it to the decoder for one or more execute cycles.
- Updates the PC from the decoder's nextPCSel selection: sequential, immediate branch target, or register target.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_WIDTH, 16, width of the PC and memory address; must be ≥ 8.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- run  input  1  fetch enable; low parks the unit in IDLE after the current instruction.
- imem_req  output  1  instruction-memory request.
- imem_addr  output  PC_WIDTH  fetch address; equals pc while imem_req is high.
- imem_ack  input  1  memory returns imem_rdata this cycle; ignored unless imem_req is high.
- imem_rdata  input  16  instruction word.
- instruction  output  16  instruction register contents, to the decoder.
- instrValid  output  1  instruction is in execute; downstream qualifies regFileWE/memWE with it.
- nextPCSel  input  2  from the decoder: 00 = pc+1, 01 = branchImm, 10 = branchReg, 11 = pc+1 (reserved).
- branchImm  input  16  decoder instrData (zero-extended 8-bit target).
- branchReg  input  16  register-file rs1 value.
- execStall  input  1  holds the execute state (e.g. a multi-cycle memory op).
- pc  output  PC_WIDTH  current PC (address of the instruction in IR while in EXEC).
- retired  output  16  count of completed instructions; wraps.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE, pc = RESET_PC, IR = 16'h0000, retired = 0.
  - imem_req = 0, instrValid = 0.
  - Reset overrides everything, including an outstanding request mid-FETCH. A pending ack is dropped and not retried.
- States: IDLE, FETCH, EXEC.
- IDLE:
  - imem_req = 0, instrValid = 0.
  - run = 1 → FETCH next cycle.
- FETCH:
  - imem_req = 1, imem_addr = pc (combinational from state and pc).
  - imem_ack = 1 → IR <= imem_rdata, go to EXEC. Zero-wait ack (ack in the first FETCH cycle) is legal, giving a 1-cycle fetch.
  - While ack is low, stay in FETCH; imem_req and imem_addr are held stable.
  - run falling during FETCH does not abort it: the request completes and the instruction executes.
- EXEC:
  - instrValid = 1; instruction = IR for the whole state.
  - execStall = 1 → stay in EXEC. pc, IR and retired are unchanged.
  - execStall = 0 → on that edge:
    - pc <= target, selected by nextPCSel sampled in that cycle:
      - 00 or 11: pc + 1, modulo 2^PC_WIDTH (0xFFFF → 0x0000 for the default width).
      - 01: branchImm[PC_WIDTH-1:0].
      - 10: branchReg[PC_WIDTH-1:0].
    - retired <= retired + 1 (0xFFFF → 0x0000).
    - Next state: FETCH if run = 1, else IDLE.
- instruction output:
  - Always reflects IR.
  - Outside EXEC it holds the last executed word. It is not meaningful there: instrValid = 0.
- imem_ack outside FETCH: no effect on any state.
- Back-to-back throughput with zero-wait memory and no stalls: one instruction per 2 cycles (FETCH, EXEC).
- nextPCSel, branchImm and branchReg are only sampled in the final EXEC cycle. Values while execStall = 1 are don't-care until the releasing cycle.

Test Plan:
- Reset then run = 1, ack tied high, rdata = 16'h1234:
  - imem_req rises the first cycle after reset release with imem_addr = 0x0000.
  - instrValid pulses on alternate cycles.
  - pc steps 0, 1, 2, …; retired increments once per EXEC.
- Ack delayed 3 cycles at pc = 0x0005:
  - imem_req and imem_addr = 0x0005 held for 4 cycles.
  - IR loads on the ack cycle; instrValid asserts the next cycle.
- Branches:
  - EXEC with nextPCSel = 01, branchImm = 0x0042 → next imem_addr = 0x0042.
  - EXEC with nextPCSel = 10, branchReg = 0x1F00 → next imem_addr = 0x1F00.
  - nextPCSel = 11 at pc = 7 → next imem_addr = 0x0008.
- execStall high for 2 cycles in EXEC:
  - instrValid stays high for 3 cycles.
  - pc and retired change only on the release edge.
- Wrap and run deassertion:
  - pc = 0xFFFF, sequential → next fetch at 0x0000.
  - retired at 0xFFFF → 0x0000.
  - run dropped mid-FETCH: request completes, one EXEC occurs, then IDLE with imem_req = 0.
- rst_n low during FETCH with ack pending:
  - Next cycle is IDLE, pc = RESET_PC, retired = 0, imem_req = 0, no EXEC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches 16-bit words over a req/ack port,
// holds them in the instruction register and steers the next PC from the decoder.
module fetch_unit #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_run,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    input  logic                i_imem_ack,
    input  logic [15:0]         i_imem_rdata,
    output logic [15:0]         o_instruction,
    output logic                o_instrValid,
    input  logic [1:0]          i_nextPCSel,
    input  logic [15:0]         i_branchImm,
    input  logic [15:0]         i_branchReg,
    input  logic                i_execStall,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic [15:0]         o_retired
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_target;
    logic [15:0]         r_ir;
    logic [15:0]         r_retired;
    logic                w_loadIr;
    logic                w_retire;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // run is only consulted in IDLE and on EXEC completion, so dropping it mid-fetch still executes
    always_comb begin
        w_nextState = r_state;
        w_loadIr    = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_run) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                if (i_imem_ack) begin
                    w_loadIr    = 1'b1;
                    w_nextState = EXEC;
                end
            end
            EXEC: begin
                if (!i_execStall) begin
                    w_retire    = 1'b1;
                    w_nextState = i_run ? FETCH : IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_target = r_pc + PC_WIDTH'(1);
        case (i_nextPCSel)
            2'b01:   w_target = PC_WIDTH'(i_branchImm);
            2'b10:   w_target = PC_WIDTH'(i_branchReg);
            default: w_target = r_pc + PC_WIDTH'(1);
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= 16'h0000;
            r_retired <= 16'h0000;
        end else begin
            if (w_loadIr) begin
                r_ir <= i_imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_target;
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign o_imem_req    = (r_state == FETCH);
    assign o_imem_addr   = r_pc;
    assign o_instrValid  = (r_state == EXEC);
    assign o_instruction = r_ir;
    assign o_pc          = r_pc;
    assign o_retired     = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic,
// every cycle compared against a phase-level reference model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        imemReq;
    logic [15:0] imemAddr;
    logic        imemAck;
    logic [15:0] imemRdata;
    logic [15:0] instruction;
    logic        instrValid;
    logic [1:0]  nextPCSel;
    logic [15:0] branchImm;
    logic [15:0] branchReg;
    logic        execStall;
    logic [15:0] pc;
    logic [15:0] retired;

    int checks   = 0;
    int failures = 0;

    localparam int PH_IDLE  = 0;
    localparam int PH_FETCH = 1;
    localparam int PH_EXEC  = 2;

    int          mPhase = PH_IDLE;
    logic [15:0] mPc    = 16'h0000;
    logic [15:0] mIr    = 16'h0000;
    logic [15:0] mRet   = 16'h0000;

    always #5 clk = ~clk;

    fetch_unit #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_run        (run),
        .o_imem_req   (imemReq),
        .o_imem_addr  (imemAddr),
        .i_imem_ack   (imemAck),
        .i_imem_rdata (imemRdata),
        .o_instruction(instruction),
        .o_instrValid (instrValid),
        .i_nextPCSel  (nextPCSel),
        .i_branchImm  (branchImm),
        .i_branchReg  (branchReg),
        .i_execStall  (execStall),
        .o_pc         (pc),
        .o_retired    (retired)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareAll();
        checkOutput("imem_req", imemReq, mPhase == PH_FETCH);
        if (mPhase == PH_FETCH) checkOutput("imem_addr", imemAddr, mPc);
        checkOutput("instrValid", instrValid, mPhase == PH_EXEC);
        checkOutput("instruction", instruction, mIr);
        checkOutput("pc", pc, mPc);
        checkOutput("retired", retired, mRet);
    endtask

    // The model advances one clock using the rules of each phase, then the DUT is compared just after the edge
    task automatic stepCycle();
        int          nPhase = mPhase;
        logic [15:0] nPc    = mPc;
        logic [15:0] nIr    = mIr;
        logic [15:0] nRet   = mRet;
        if (!rst_n) begin
            nPhase = PH_IDLE;
            nPc    = 16'h0000;
            nIr    = 16'h0000;
            nRet   = 16'h0000;
        end else if (mPhase == PH_IDLE) begin
            if (run) nPhase = PH_FETCH;
        end else if (mPhase == PH_FETCH) begin
            if (imemAck) begin
                nIr    = imemRdata;
                nPhase = PH_EXEC;
            end
        end else if (!execStall) begin
            if (nextPCSel == 2'b01)      nPc = branchImm;
            else if (nextPCSel == 2'b10) nPc = branchReg;
            else                         nPc = mPc + 16'd1;
            nRet   = mRet + 16'd1;
            nPhase = run ? PH_FETCH : PH_IDLE;
        end
        @(posedge clk);
        #1;
        mPhase = nPhase;
        mPc    = nPc;
        mIr    = nIr;
        mRet   = nRet;
        compareAll();
    endtask

    task automatic applyStimulus(input logic rn, input logic rr, input logic ack, input logic [15:0] rdata,
                                 input logic [1:0] sel, input logic [15:0] imm, input logic [15:0] rv,
                                 input logic stall);
        rst_n     = rn;
        run       = rr;
        imemAck   = ack;
        imemRdata = rdata;
        nextPCSel = sel;
        branchImm = imm;
        branchReg = rv;
        execStall = stall;
        stepCycle();
    endtask

    task automatic advanceTo(input int ph);
        for (int i = 0; i < 20 && mPhase != ph; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 2'b00, 16'h0, 16'h0, 1'b0);
        if (mPhase != ph) checkOutput("advance_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("reset_req", imemReq, 1'b0);
        checkOutput("reset_pc", pc, 16'h0000);

        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("first_req", imemReq, 1'b1);
        checkOutput("first_addr", imemAddr, 16'h0000);
        for (int i = 0; i < 8; i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 2'b00, 16'h0, 16'h0, 1'b0);

        for (int i = 0; i < 40 && !(mPhase == PH_FETCH && mPc == 16'h0005); i++)
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h1234, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("reach_pc5", pc, 16'h0005);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'hDEAD, 2'b00, 16'h0, 16'h0, 1'b0);
            checkOutput("dly_req", imemReq, 1'b1);
            checkOutput("dly_addr", imemAddr, 16'h0005);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hABCD, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("dly_ir", instruction, 16'hABCD);
        checkOutput("dly_valid", instrValid, 1'b1);

        advanceTo(PH_EXEC);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h1111, 2'b01, 16'h0042, 16'h0, 1'b0);
        checkOutput("br_imm_addr", imemAddr, 16'h0042);
        advanceTo(PH_EXEC);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h2222, 2'b10, 16'h0, 16'h1F00, 1'b0);
        checkOutput("br_reg_addr", imemAddr, 16'h1F00);
        advanceTo(PH_EXEC);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h3333, 2'b01, 16'h0007, 16'h0, 1'b0);
        advanceTo(PH_EXEC);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h4444, 2'b11, 16'h0099, 16'h0, 1'b0);
        checkOutput("sel11_addr", imemAddr, 16'h0008);

        advanceTo(PH_EXEC);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 2'(i + 1), 16'h00EE, 16'h00DD, 1'b1);
            checkOutput("stall_valid", instrValid, 1'b1);
            checkOutput("stall_pc", pc, 16'h0008);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h5555, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("stall_release_pc", pc, 16'h0009);

        advanceTo(PH_EXEC);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h6666, 2'b10, 16'h0, 16'hFFFF, 1'b0);
        advanceTo(PH_EXEC);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h7777, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("wrap_addr", imemAddr, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0, 16'h8888, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("rundrop_req", imemReq, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h8888, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("rundrop_exec", instrValid, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h8888, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("rundrop_idle_req", imemReq, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 16'h8888, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("rundrop_idle_valid", instrValid, 1'b0);

        advanceTo(PH_FETCH);
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h9999, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("midreset_req", imemReq, 1'b0);
        checkOutput("midreset_valid", instrValid, 1'b0);
        checkOutput("midreset_pc", pc, 16'h0000);
        checkOutput("midreset_ret", retired, 16'h0000);
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h9999, 2'b00, 16'h0, 16'h0, 1'b0);
        checkOutput("midreset_noexec", instrValid, 1'b0);

        // Random traffic: mostly running, frequent ack delays and stalls, rare resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 2) != 0),
                          16'($urandom),
                          2'($urandom),
                          16'($urandom_range(0, 255)),
                          16'($urandom),
                          ($urandom_range(0, 3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
